// File: rtl/mem_responder.sv
// Memory-side responder: accepts READ/WRITE commands, inserts a fixed number of
// wait states, serves the access from an internal word RAM and acknowledges with mem_ready.
module mem_responder #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 9,
  parameter int MEM_WORDS_LOG2 = 8,
  parameter int WAIT_STATES    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            mem_cmd,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  mem_ready,
  output logic                  busy,
  output logic                  mem_hit
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  localparam logic [3:0] WCNT_INIT = 4'(WAIT_STATES - 1);
  localparam int         MEM_WORDS = 2 ** MEM_WORDS_LOG2;

  logic [1:0]                state;
  logic [1:0]                state_nxt;
  logic [3:0]                wcnt;
  logic                      accept;
  logic                      lat_wr;
  logic [MEM_WORDS_LOG2-1:0] lat_addr;
  logic [DATA_WIDTH-1:0]     lat_data;
  logic [DATA_WIDTH-1:0]     ram [MEM_WORDS];

  assign mem_hit = (mem_addr[ADDR_WIDTH-1:MEM_WORDS_LOG2] == '0);
  assign accept  = mem_hit && ((mem_cmd == CMD_READ) || (mem_cmd == CMD_WRITE));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (wcnt == 4'd0) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Control path: mem_ready and busy are registered copies of the next-state decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      wcnt      <= 4'd0;
      dout      <= '0;
      mem_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      mem_ready <= (state == S_ACCESS);
      busy      <= (state_nxt != S_IDLE);
      if (state == S_IDLE && accept) begin
        wcnt <= WCNT_INIT;
      end else if (state == S_WAIT && wcnt != 4'd0) begin
        wcnt <= wcnt - 4'd1;
      end
      if (state == S_ACCESS && !lat_wr) begin
        dout <= ram[lat_addr];
      end
    end
  end

  // Transaction latches and RAM carry no reset; an aborted write never reaches ACCESS.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && accept) begin
      lat_wr   <= (mem_cmd == CMD_WRITE);
      lat_addr <= mem_addr[MEM_WORDS_LOG2-1:0];
      lat_data <= write_data;
    end
    if (state == S_ACCESS && lat_wr) begin
      ram[lat_addr] <= lat_data;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT_STATES 0, 1, 3) checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_mem_responder;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic [2:0][1:0]  cmd;
  logic [2:0][8:0]  addr;
  logic [2:0][15:0] wd;
  logic [2:0][15:0] dout;
  logic [2:0]       rdy;
  logic [2:0]       bsy;
  logic [2:0]       hit;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(9), .MEM_WORDS_LOG2(8), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset_n(reset_n), .mem_cmd(cmd[0]), .mem_addr(addr[0]), .write_data(wd[0]),
    .dout(dout[0]), .mem_ready(rdy[0]), .busy(bsy[0]), .mem_hit(hit[0]));
  mem_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(9), .MEM_WORDS_LOG2(8), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset_n(reset_n), .mem_cmd(cmd[1]), .mem_addr(addr[1]), .write_data(wd[1]),
    .dout(dout[1]), .mem_ready(rdy[1]), .busy(bsy[1]), .mem_hit(hit[1]));
  mem_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(9), .MEM_WORDS_LOG2(8), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset_n(reset_n), .mem_cmd(cmd[2]), .mem_addr(addr[2]), .write_data(wd[2]),
    .dout(dout[2]), .mem_ready(rdy[2]), .busy(bsy[2]), .mem_hit(hit[2]));

  function automatic int ws(int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 3;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tot_cnt++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // Model: t = cycles since capture (0 = idle); the access lands on the edge where t reaches ws+2.
  int          t      [3];
  logic        m_wr   [3];
  logic [7:0]  m_addr [3];
  logic [15:0] m_data [3];
  logic [15:0] m_dout [3];
  logic [15:0] m_mem  [3][256];

  initial for (int k = 0; k < 3; k++) begin
    t[k] = 0;
    m_dout[k] = 16'h0;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!reset_n) begin
        t[k] = 0;
        m_dout[k] = 16'h0;
      end else if (t[k] > 0) begin
        if (t[k] == ws(k) + 2) t[k] = 0;
        else begin
          t[k]++;
          if (t[k] == ws(k) + 2) begin
            if (m_wr[k]) m_mem[k][m_addr[k]] = m_data[k];
            else m_dout[k] = m_mem[k][m_addr[k]];
          end
        end
      end else if ((cmd[k] == 2'b01 || cmd[k] == 2'b10) && addr[k][8] == 1'b0) begin
        m_wr[k]   = (cmd[k] == 2'b10);
        m_addr[k] = addr[k][7:0];
        m_data[k] = wd[k];
        t[k]      = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("busy[%0d]", k), 32'(bsy[k]), reset_n ? 32'(t[k] > 0) : 32'd0);
        chk($sformatf("mem_ready[%0d]", k), 32'(rdy[k]), reset_n ? 32'(t[k] == ws(k) + 2) : 32'd0);
        chk($sformatf("dout[%0d]", k), 32'(dout[k]), reset_n ? 32'(m_dout[k]) : 32'd0);
        chk($sformatf("mem_hit[%0d]", k), 32'(hit[k]), 32'(addr[k][8] == 1'b0));
      end
    end
  end

  task automatic wait_rdy(int k, output int at);
    bit found = 1'b0;
    at = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rdy[k]) begin
        found = 1'b1;
        at = cyc;
        break;
      end
    end
    if (!found) chk($sformatf("ready_timeout[%0d]", k), 32'd0, 32'd1);
  endtask

  // Issue one command; lat = edges after the capture edge until mem_ready is seen.
  task automatic run(int k, logic [1:0] c, logic [8:0] a, logic [15:0] d, bit hold, bit chg,
                     logic [8:0] a2, logic [15:0] d2, output int lat, output int at);
    int e0;
    @(posedge clk); #1;
    cmd[k] = c; addr[k] = a; wd[k] = d;
    e0 = cyc + 1;
    @(posedge clk); #1;
    if (chg) begin
      addr[k] = a2; wd[k] = d2;
    end
    wait_rdy(k, at);
    lat = at - e0;
    if (!hold) cmd[k] = 2'b00;
  endtask

  initial begin
    int lat, at1, at2;
    cmd = '0; addr = '0; wd = '0;
    #1 reset_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dout", 32'(dout[1]), 32'h0);
    chk("reset_ready", 32'(rdy[1]), 32'h0);
    chk("reset_busy", 32'(bsy[1]), 32'h0);
    reset_n = 1'b1;

    // WAIT_STATES=1: write then read back
    run(1, 2'b10, 9'h005, 16'hBEEF, 0, 0, 9'h0, 16'h0, lat, at1);
    chk("ws1_write_latency", 32'(lat), 32'd2);
    run(1, 2'b01, 9'h005, 16'h0000, 0, 0, 9'h0, 16'h0, lat, at1);
    chk("ws1_read_latency", 32'(lat), 32'd2);
    chk("ws1_read_data", 32'(dout[1]), 32'hBEEF);

    // WAIT_STATES=0: preload, read, back-to-back spacing
    run(0, 2'b10, 9'h0FF, 16'h0FF0, 0, 0, 9'h0, 16'h0, lat, at1);
    run(0, 2'b01, 9'h0FF, 16'h0000, 0, 0, 9'h0, 16'h0, lat, at1);
    chk("ws0_read_latency", 32'(lat), 32'd1);
    chk("ws0_read_data", 32'(dout[0]), 32'h0FF0);
    run(0, 2'b01, 9'h0FF, 16'h0000, 1, 0, 9'h0, 16'h0, lat, at1);
    wait_rdy(0, at2);
    cmd[0] = 2'b00;
    chk("ws0_b2b_spacing", 32'(at2 - at1), 32'd3);

    // Miss and reserved command
    @(posedge clk); #1;
    cmd[1] = 2'b01; addr[1] = 9'h140;
    repeat (4) begin
      @(negedge clk);
      chk("miss_hit", 32'(hit[1]), 32'h0);
      chk("miss_busy", 32'(bsy[1]), 32'h0);
      chk("miss_ready", 32'(rdy[1]), 32'h0);
    end
    chk("miss_dout", 32'(dout[1]), 32'hBEEF);
    cmd[1] = 2'b11; addr[1] = 9'h005;
    repeat (4) begin
      @(negedge clk);
      chk("cmd11_hit", 32'(hit[1]), 32'h1);
      chk("cmd11_busy", 32'(bsy[1]), 32'h0);
    end
    chk("cmd11_dout", 32'(dout[1]), 32'hBEEF);
    cmd[1] = 2'b00;

    // Input changes during WAIT are ignored
    run(1, 2'b10, 9'h020, 16'h7777, 0, 0, 9'h0, 16'h0, lat, at1);
    run(1, 2'b10, 9'h010, 16'h1234, 0, 1, 9'h020, 16'hFFFF, lat, at1);
    run(1, 2'b01, 9'h010, 16'h0000, 0, 0, 9'h0, 16'h0, lat, at1);
    chk("latched_write_data", 32'(dout[1]), 32'h1234);
    run(1, 2'b01, 9'h020, 16'h0000, 0, 0, 9'h0, 16'h0, lat, at1);
    chk("untouched_addr", 32'(dout[1]), 32'h7777);

    // Reset during WAIT discards the pending write
    run(1, 2'b10, 9'h003, 16'h5555, 0, 0, 9'h0, 16'h0, lat, at1);
    @(posedge clk); #1;
    cmd[1] = 2'b10; addr[1] = 9'h003; wd[1] = 16'hAAAA;
    @(posedge clk); #1;
    chk("pre_reset_busy", 32'(bsy[1]), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_busy", 32'(bsy[1]), 32'h0);
    chk("async_reset_ready", 32'(rdy[1]), 32'h0);
    chk("async_reset_dout", 32'(dout[1]), 32'h0);
    cmd[1] = 2'b00;
    @(posedge clk); #1;
    reset_n = 1'b1;
    run(1, 2'b01, 9'h003, 16'h0000, 0, 0, 9'h0, 16'h0, lat, at1);
    chk("aborted_write_read", 32'(dout[1]), 32'h5555);

    // WAIT_STATES=3: held READ is re-accepted
    run(2, 2'b10, 9'h044, 16'h1357, 0, 0, 9'h0, 16'h0, lat, at1);
    chk("ws3_write_latency", 32'(lat), 32'd4);
    run(2, 2'b01, 9'h044, 16'h0000, 1, 0, 9'h0, 16'h0, lat, at1);
    chk("ws3_read_data", 32'(dout[2]), 32'h1357);
    wait_rdy(2, at2);
    cmd[2] = 2'b00;
    chk("ws3_reaccept_spacing", 32'(at2 - at1), 32'd6);

    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
